// File: rtl/ingress_req_arb.sv
// Per-input ingress FIFOs with destination decode and one round-robin arbiter
// per output port; drives a registered one-hot-per-row request matrix.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module ingress_req_arb #(
    parameter int PORT_NUB   = `PORT_NUB_TOTAL,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_W      = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PORT_NUB-1:0]            in_valid,
    output logic [PORT_NUB-1:0]            in_ready,
    input  logic [PORT_NUB*DATA_WIDTH-1:0] in_data,
    input  logic [PORT_NUB*SEL_W-1:0]      in_dest,
    input  logic [PORT_NUB-1:0]            out_ready,
    output logic [PORT_NUB*PORT_NUB-1:0]   port_vaild,
    output logic [PORT_NUB*DATA_WIDTH-1:0] out_data,
    output logic [PORT_NUB-1:0]            drop_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    // Handshake: a word moves into input j's FIFO on a rising edge where
    // in_valid[j] && in_ready[j]; in_ready[j] depends only on FIFO state.

    logic [DATA_WIDTH-1:0] mem_data [PORT_NUB][FIFO_DEPTH];
    logic [SEL_W-1:0]      mem_dest [PORT_NUB][FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr   [PORT_NUB];
    logic [PW-1:0]         rd_ptr   [PORT_NUB];
    logic [DATA_WIDTH-1:0] head_data[PORT_NUB];
    logic [SEL_W-1:0]      head_dest[PORT_NUB];
    logic [SEL_W-1:0]      rr_ptr   [PORT_NUB];
    logic [SEL_W-1:0]      winner   [PORT_NUB];
    logic [PORT_NUB-1:0]   grant    [PORT_NUB];

    logic [PORT_NUB-1:0]          full;
    logic [PORT_NUB-1:0]          empty;
    logic [PORT_NUB-1:0]          push;
    logic [PORT_NUB-1:0]          pop;
    logic [PORT_NUB-1:0]          dest_ok;
    logic [PORT_NUB-1:0]          drop;
    logic [PORT_NUB-1:0]          row_hit;
    logic [PORT_NUB-1:0]          col_hit;
    logic [PORT_NUB*PORT_NUB-1:0] grant_flat;

    always_comb begin
        for (int j = 0; j < PORT_NUB; j++) begin
            full[j]      = (wr_ptr[j][AW] != rd_ptr[j][AW]) &&
                           (wr_ptr[j][AW-1:0] == rd_ptr[j][AW-1:0]);
            empty[j]     = (wr_ptr[j] == rd_ptr[j]);
            head_data[j] = mem_data[j][rd_ptr[j][AW-1:0]];
            head_dest[j] = mem_dest[j][rd_ptr[j][AW-1:0]];
            dest_ok[j]   = 1'b0;
            for (int d = 0; d < PORT_NUB; d++) begin
                if (head_dest[j] == SEL_W'(d)) begin
                    dest_ok[j] = 1'b1;
                end
            end
            drop[j] = !empty[j] && !dest_ok[j];
        end
    end

    assign in_ready = ~full;
    assign push     = in_valid & ~full;

    // Search upward from rr_ptr[i]; the first requesting input wins the row.
    always_comb begin : arb
        int               idx;
        logic [SEL_W-1:0] cand;
        idx  = 0;
        cand = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            grant[i]   = '0;
            winner[i]  = '0;
            row_hit[i] = 1'b0;
            if (out_ready[i]) begin
                for (int k = 0; k < PORT_NUB; k++) begin
                    idx = int'(rr_ptr[i]) + k;
                    if (idx >= PORT_NUB) begin
                        idx = idx - PORT_NUB;
                    end
                    cand = SEL_W'(idx);
                    if (!row_hit[i] && !empty[cand] && (head_dest[cand] == SEL_W'(i))) begin
                        row_hit[i]     = 1'b1;
                        winner[i]      = cand;
                        grant[i][cand] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        col_hit    = '0;
        grant_flat = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            col_hit                            = col_hit | grant[i];
            grant_flat[i*PORT_NUB +: PORT_NUB] = grant[i];
        end
    end

    // Bad-destination heads leave unconditionally so they never block the FIFO.
    assign pop = col_hit | drop;

    always_ff @(posedge clk) begin
        for (int j = 0; j < PORT_NUB; j++) begin
            if (push[j]) begin
                mem_data[j][wr_ptr[j][AW-1:0]] <= in_data[j*DATA_WIDTH +: DATA_WIDTH];
                mem_dest[j][wr_ptr[j][AW-1:0]] <= in_dest[j*SEL_W +: SEL_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < PORT_NUB; j++) begin
                wr_ptr[j] <= '0;
                rd_ptr[j] <= '0;
            end
        end else begin
            for (int j = 0; j < PORT_NUB; j++) begin
                if (push[j]) begin
                    wr_ptr[j] <= wr_ptr[j] + 1'b1;
                end
                if (pop[j]) begin
                    rd_ptr[j] <= rd_ptr[j] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PORT_NUB; i++) begin
                rr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PORT_NUB; i++) begin
                if (row_hit[i]) begin
                    rr_ptr[i] <= (winner[i] == SEL_W'(PORT_NUB - 1)) ? '0 : winner[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_vaild <= '0;
            out_data   <= '0;
            drop_err   <= '0;
        end else begin
            port_vaild <= grant_flat;
            drop_err   <= drop;
            for (int j = 0; j < PORT_NUB; j++) begin
                if (col_hit[j]) begin
                    out_data[j*DATA_WIDTH +: DATA_WIDTH] <= head_data[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_ingress_req_arb.sv
// Directed bench for ingress_req_arb: a scoreboard queue of expected
// {row, col, data} words checked by a monitor, plus cycle-exact matrix checks.
module tb_ingress_req_arb;

  localparam int P  = 4;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int EW = SW + SW + DW;

  logic             clk;
  logic             rst_n;
  logic [P-1:0]     in_valid;
  logic [P-1:0]     in_ready;
  logic [P*DW-1:0]  in_data;
  logic [P*SW-1:0]  in_dest;
  logic [P-1:0]     out_ready;
  logic [P*P-1:0]   port_vaild;
  logic [P*DW-1:0]  out_data;
  logic [P-1:0]     drop_err;

  int checks = 0;
  int errors = 0;
  int col3_cnt = 0;
  logic [EW-1:0] exp_q[$];

  ingress_req_arb #(
    .PORT_NUB  (P),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_ready (out_ready),
    .port_vaild(port_vaild),
    .out_data  (out_data),
    .drop_err  (drop_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int j, input logic [DW-1:0] d, input logic [SW-1:0] dst);
    in_valid[j]           = 1'b1;
    in_data[j*DW +: DW]   = d;
    in_dest[j*SW +: SW]   = dst;
  endtask

  task automatic clear_valid();
    in_valid = '0;
  endtask

  task automatic expect_word(input int row, input int col, input logic [DW-1:0] d);
    exp_q.push_back({SW'(row), SW'(col), d});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < P; i++) begin
        check("row_onehot", 64'($countones(port_vaild[i*P +: P]) <= 1), 64'd1);
        for (int j = 0; j < P; j++) begin
          if (port_vaild[i*P+j]) begin
            logic [EW-1:0] got;
            got = {SW'(i), SW'(j), out_data[j*DW +: DW]};
            if (j == 3) col3_cnt++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_grant: got row %0d col %0d data %0h, expected none",
                       i, j, out_data[j*DW +: DW]);
            end else begin
              check("grant_word", 64'(got), 64'(exp_q.pop_front()));
            end
          end
        end
      end
      for (int j = 0; j < P; j++) begin
        int c;
        c = 0;
        for (int i = 0; i < P; i++) c += int'(port_vaild[i*P+j]);
        check("col_onehot", 64'(c <= 1), 64'd1);
      end
      check("drop_err_idle", 64'(drop_err), 64'd0);
    end
  end

  // stimulus
  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_dest   = '0;
    out_ready = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("reset_port_vaild", 64'(port_vaild), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'hF);
    check("reset_drop_err", 64'(drop_err), 64'd0);

    // single word, dest 2 from in0
    set_word(0, 16'hA5A5, 2'd2);
    expect_word(2, 0, 16'hA5A5);
    tick();
    clear_valid();
    check("single_n1", 64'(port_vaild), 64'd0);
    tick();
    check("single_n2", 64'(port_vaild), 64'h0100);
    check("single_data", 64'(out_data[15:0]), 64'hA5A5);
    tick();
    check("single_pulse", 64'(port_vaild), 64'd0);

    // contention: in1..in3 two words each to output 0
    out_ready = 4'b1110;
    for (int w = 0; w < 2; w++) begin
      for (int j = 1; j < 4; j++) begin
        set_word(j, DW'(16'h1000 * j + w), 2'd0);
        expect_word(0, j, DW'(16'h1000 * j + w));
      end
      tick();
    end
    clear_valid();
    tick();
    check("contend_blocked", 64'(port_vaild), 64'd0);
    out_ready = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      logic [15:0] exp_pv;
      exp_pv = 16'h0001 << ((c % 3) + 1);
      tick();
      check("contend_order", 64'(port_vaild), 64'(exp_pv));
    end
    tick();
    check("contend_done", 64'(port_vaild), 64'd0);

    // parallel grants across all outputs
    set_word(0, 16'hC003, 2'd3);
    set_word(1, 16'hC102, 2'd2);
    set_word(2, 16'hC201, 2'd1);
    set_word(3, 16'hC300, 2'd0);
    expect_word(0, 3, 16'hC300);
    expect_word(1, 2, 16'hC201);
    expect_word(2, 1, 16'hC102);
    expect_word(3, 0, 16'hC003);
    tick();
    clear_valid();
    tick();
    check("parallel_matrix", 64'(port_vaild), 64'h1248);
    check("parallel_data", 64'(out_data), 64'hC300_C201_C102_C003);
    tick();
    check("parallel_pulse", 64'(port_vaild), 64'd0);

    // back-pressure on output 1
    out_ready = 4'b1101;
    for (int w = 0; w < 4; w++) begin
      set_word(2, DW'(16'h2B00 + w), 2'd1);
      expect_word(1, 2, DW'(16'h2B00 + w));
      tick();
      check("bp_row1_quiet", 64'(port_vaild[7:4]), 64'd0);
    end
    clear_valid();
    check("bp_in2_full", 64'(in_ready[2]), 64'd0);
    tick();
    check("bp_row1_quiet", 64'(port_vaild[7:4]), 64'd0);
    out_ready = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp_drain", 64'(port_vaild), 64'h0040);
    end
    tick();
    check("bp_drain_done", 64'(port_vaild), 64'd0);
    check("bp_in2_ready", 64'(in_ready[2]), 64'd1);

    // FIFO full boundary on in3
    out_ready = 4'b0000;
    for (int w = 0; w < 4; w++) begin
      set_word(3, DW'(16'h3F00 + w), 2'd1);
      expect_word(1, 3, DW'(16'h3F00 + w));
      tick();
    end
    check("full_in3_ready", 64'(in_ready[3]), 64'd0);
    set_word(3, 16'hDEAD, 2'd1);
    tick();
    clear_valid();
    check("full_in3_still", 64'(in_ready[3]), 64'd0);
    col3_cnt  = 0;
    out_ready = 4'b1111;
    repeat (8) tick();
    check("full_drain_count", 64'(col3_cnt), 64'd4);
    check("full_in3_free", 64'(in_ready[3]), 64'd1);

    // reset with words buffered
    out_ready = 4'b0000;
    set_word(0, 16'h7777, 2'd0);
    set_word(1, 16'h8888, 2'd2);
    tick();
    clear_valid();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_port_vaild", 64'(port_vaild), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'hF);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 4'b1111;
    repeat (4) begin
      tick();
      check("midrst_no_grant", 64'(port_vaild), 64'd0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
